// File: rtl/fixedpoint_seqmul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixedpoint_seqmul: unsigned fixed-point shift-add multiplier, one partial |
// | product per cycle, round-half-up to OUT_FRAC. Option macro: FXP_SAT_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fixedpoint_seqmul #(
  parameter int IN_W     = 8,
  parameter int IN_FRAC  = 5,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int c_pw = 2 * IN_W;
  localparam int c_s  = 2 * IN_FRAC - OUT_FRAC;
  localparam int c_cw = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(IN_W - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_mul  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_next;
  logic [c_cw-1:0] r_cnt;
  logic [c_pw-1:0] r_a;
  logic [IN_W-1:0] r_b;
  logic [c_pw-1:0] r_acc;
  logic [c_pw-1:0] w_acc_next;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out;
  logic            w_last;

  assign w_last     = (r_cnt == c_last);
  // Multiplicand walks left, multiplier walks right: bit i of in2 meets in1<<i.
  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (in_valid)  w_state_next = c_mul;
      c_mul:   if (w_last)    w_state_next = c_done;
      c_done:  if (out_ready) w_state_next = c_idle;
      default:                w_state_next = c_idle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_idle);
    out_valid = (r_state == c_done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else if (r_state == c_idle && in_valid) begin
      r_a   <= c_pw'(in1);
      r_b   <= in2;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == c_mul) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_out <= w_out;
    end
  end

  assign out = r_out;

  // (P + 2^(S-1)) >> S is the same as (P >> S) plus the bit just below the cut.
`ifdef FXP_SAT_EN
  localparam int c_rw = c_pw - c_s + 1;

  logic [c_rw-1:0] w_r;
  logic            w_ovf;
  logic            r_ovf;

  assign w_r   = {1'b0, w_acc_next[c_pw-1:c_s]} + c_rw'(w_acc_next[c_s-1]);
  assign w_ovf = |(w_r >> OUT_W);
  assign w_out = w_ovf ? '1 : w_r[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == c_mul && w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_out = w_acc_next[c_s +: OUT_W] + OUT_W'(w_acc_next[c_s-1]);
  assign ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fixedpoint_seqmul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fixedpoint_seqmul: vector table + scoreboard bench for the multiplier. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fixedpoint_seqmul;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eout;
    logic       eovf;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in1, in2, out;
  logic       in_valid, in_ready, out_valid, out_ready, ovf;
  logic [7:0] in1b, in2b, outb;
  logic       in_validb, in_readyb, out_validb, out_readyb, ovfb;

  exp_t       sb[$];
  exp_t       last_exp;
  int         checks = 0;
  int         errors = 0;

  fixedpoint_seqmul dut (
    .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  fixedpoint_seqmul #(.IN_W(8), .IN_FRAC(4), .OUT_W(8), .OUT_FRAC(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .in1(in1b), .in2(in2b), .in_valid(in_validb),
    .in_ready(in_readyb), .out(outb), .out_valid(out_validb), .out_ready(out_readyb), .ovf(ovfb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Default format: Q3.5 x Q3.5 -> Q6.2, drop 8 bits with round-half-up.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    int unsigned p;
    int unsigned r;
    p = 32'(a) * 32'(b);
    r = (p + 32'd128) >> 8;
`ifdef FXP_SAT_EN
    if (r >= 256) begin
      e.out = 8'hff;
      e.ovf = 1'b1;
    end else begin
      e.out = r[7:0];
      e.ovf = 1'b0;
    end
`else
    e.out = r[7:0];
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic start_txn(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic await_result(input bit toggle);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (toggle) begin
        in1 = 8'($urandom);
        in2 = 8'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd8);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      last_exp = sb.pop_front();
      check("out", 32'(out), 32'(last_exp.out));
      check("ovf", 32'(ovf), 32'(last_exp.ovf));
    end
  endtask

  task automatic hold_and_release(input int hold);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out", 32'(out), 32'(last_exp.out));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", 32'(in_ready), 32'd1);
    check("release_valid_low", 32'(out_valid), 32'd0);
    check("retain_out", 32'(out), 32'(last_exp.out));
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input exp_t e,
                         input int hold, input bit toggle);
    start_txn(a, b, e);
    await_result(toggle);
    hold_and_release(hold);
  endtask

  initial begin
    vec_t vecs[9];
    exp_t e;
    int   lat;

    vecs[0] = '{8'he0, 8'he0, 8'hc4, 1'b0};
    vecs[1] = '{8'h28, 8'h60, 8'h0f, 1'b0};
    vecs[2] = '{8'h28, 8'h10, 8'h03, 1'b0};
    vecs[3] = '{8'h00, 8'hff, 8'h00, 1'b0};
    vecs[4] = '{8'hff, 8'hff, 8'hfe, 1'b0};
    vecs[5] = '{8'h20, 8'h20, 8'h04, 1'b0};
    vecs[6] = '{8'h40, 8'h02, 8'h01, 1'b0};
    vecs[7] = '{8'h7f, 8'h01, 8'h00, 1'b0};
    vecs[8] = '{8'hff, 8'h00, 8'h00, 1'b0};

    rst_n = 1'b0;
    in1 = 8'h0; in2 = 8'h0; in_valid = 1'b0; out_ready = 1'b0;
    in1b = 8'h0; in2b = 8'h0; in_validb = 1'b0; out_readyb = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      e.out = vecs[i].eout;
      e.ovf = vecs[i].eovf;
      run_txn(vecs[i].a, vecs[i].b, e, (i == 1) ? 2 : 0, 1'b0);
    end

    // Backpressure with a new request queued behind the held result.
    e.out = 8'h03; e.ovf = 1'b0;
    start_txn(8'h28, 8'h10, e);
    await_result(1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'h03);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in1 = 8'he0; in2 = 8'he0; in_valid = 1'b1;
    e.out = 8'hc4; e.ovf = 1'b0;
    sb.push_back(e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_back_idle", 32'(in_ready), 32'd1);
    check("bp_valid_low", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_queued_accepted", 32'(in_ready), 32'd0);
    await_result(1'b0);
    hold_and_release(0);

    // Asynchronous reset in the middle of a multiply.
    e.out = 8'h0f; e.ovf = 1'b0;
    start_txn(8'h28, 8'h60, e);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_rst_out", 32'(out), 32'd0);
    check("amid_rst_ovf", 32'(ovf), 32'd0);
    check("amid_rst_out_valid", 32'(out_valid), 32'd0);
    check("amid_rst_in_ready", 32'(in_ready), 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    e.out = 8'h0f; e.ovf = 1'b0;
    run_txn(8'h28, 8'h60, e, 0, 1'b0);

    // Operands wiggle during the multiply; the captured pair must win.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      run_txn(a, b, model(a, b), 1, 1'b1);
    end

    // Q4.4 x Q4.4 -> Q6.2 where the rounded result needs 10 bits.
    @(negedge clk);
    in1b = 8'hff; in2b = 8'hff; in_validb = 1'b1;
    @(negedge clk);
    in_validb = 1'b0;
    lat = 0;
    while (!out_validb && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("q44_latency", 32'(lat), 32'd8);
`ifdef FXP_SAT_EN
    check("q44_out", 32'(outb), 32'hff);
    check("q44_ovf", 32'(ovfb), 32'd1);
`else
    check("q44_out", 32'(outb), 32'hf8);
    check("q44_ovf", 32'(ovfb), 32'd0);
`endif
    out_readyb = 1'b1;
    @(negedge clk);
    out_readyb = 1'b0;
    check("q44_idle", 32'(in_readyb), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
